// File: rtl/regfile_pkg.sv
// regfile_pkg: select-field encodings and unpack helpers shared by the register file
package regfile_pkg;
    localparam logic [1:0] MODE_FULL = 2'b00;
    localparam logic [1:0] MODE_RSVD = 2'b01;
    localparam logic [1:0] MODE_HI   = 2'b10;
    localparam logic [1:0] MODE_LO   = 2'b11;

    function automatic logic [1:0] sel_mode(input logic [31:0] sel, input int idx_w);
        return sel[idx_w +: 2];
    endfunction

    function automatic logic [31:0] sel_idx(input logic [31:0] sel, input int idx_w);
        return sel & ((32'd1 << idx_w) - 32'd1);
    endfunction
endpackage

// File: rtl/regfile_wr_merge.sv
// regfile_wr_merge: next value of one register after applying all write ports in ascending order
module regfile_wr_merge
    import regfile_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NWR    = 2,
    parameter int IDX_W  = 3,
    parameter int MY_IDX = 1
) (
    input  logic [DATA_W-1:0]         cur,
    input  logic [NWR*(IDX_W+2)-1:0]  wr_sel,
    input  logic [NWR*DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]         nxt,
    output logic                      hit
);
    localparam int SEL_W = IDX_W + 2;
    localparam int H = DATA_W / 2;
    logic [SEL_W-1:0] s;
    logic [1:0] m;
    logic [DATA_W-1:0] d;
    always_comb begin
        nxt = cur;
        hit = 1'b0;
        s = '0;
        m = '0;
        d = '0;
        for (int k = 0; k < NWR; k++) begin
            s = wr_sel[k*SEL_W +: SEL_W];
            d = wr_data[k*DATA_W +: DATA_W];
            m = sel_mode(32'(s), IDX_W);
            if (m != MODE_RSVD && sel_idx(32'(s), IDX_W) == 32'(MY_IDX)) begin
                hit = 1'b1;
                nxt = m == MODE_FULL ? d :
                      m == MODE_HI   ? {d[H-1:0], nxt[H-1:0]} : {nxt[DATA_W-1:H], d[H-1:0]};
            end
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with half access, optional bypass and pending-write scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int NWR    = 2,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int IDX_W  = $clog2(NREG),
    parameter int SEL_W  = IDX_W + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NWR*SEL_W-1:0]  wr_sel,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic [NRD*SEL_W-1:0]  rd_sel,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  rsv_valid,
    input  logic [IDX_W-1:0]      rsv_idx,
    output logic                  rsv_ready
);
    localparam int H = DATA_W / 2;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:1] hit;
    logic [NREG-1:1] busy_q, busy_d;
    logic [NREG-1:0] busy;

    assign regs_d[0] = '0;
    for (genvar r = 1; r < NREG; r++) begin : g_reg
        regfile_wr_merge #(.DATA_W(DATA_W), .NWR(NWR), .IDX_W(IDX_W), .MY_IDX(r)) u_merge (
            .cur(regs_q[r]), .wr_sel(wr_sel), .wr_data(wr_data), .nxt(regs_d[r]), .hit(hit[r])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= regs_d[r];
            busy_q <= busy_d;
        end
    end

    assign busy = {busy_q, 1'b0};
    assign rsv_ready = rsv_valid & ~busy[rsv_idx];

    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++)
            busy_d[r] = (rsv_ready && rsv_idx == IDX_W'(r)) || (busy_q[r] && !hit[r]);
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [SEL_W-1:0] s;
        logic [1:0] m;
        logic [IDX_W-1:0] ix;
        logic [DATA_W-1:0] v;
        assign s = rd_sel[p*SEL_W +: SEL_W];
        assign m = sel_mode(32'(s), IDX_W);
        assign ix = IDX_W'(sel_idx(32'(s), IDX_W));
        assign v = BYPASS != 0 ? regs_d[ix] : regs_q[ix];
        assign rd_data[p*DATA_W +: DATA_W] = m == MODE_RSVD ? '0 :
                                             m == MODE_FULL ? v :
                                             m == MODE_HI   ? DATA_W'(v[DATA_W-1:H]) : DATA_W'(v[H-1:0]);
        assign rd_busy[p] = m != MODE_RSVD && busy[ix];
    end
endmodule
